univ_shift_register: RTL and testbench
======================================

// Module: univ_shift_register
// PURPOSE
//   Parametrised universal shift register: the next generation of our serial shifter.
//   Per-cycle modes: hold, shift right, shift left, parallel load.
//   Adds an FSM-driven burst engine that shifts N positions on one start command,
//   with busy/done status.
//   Used for serialisers, deserialisers and barrel-style staged shifts in datapaths.
// PARAMETERS
//   WIDTH  8                   register width in bits, >= 2
//   CW     $clog2(WIDTH)+1     width of the burst amount (localparam, derived)
// PORTS
//   clk      in   1      clock; all state updates on its rising edge
//   reset    in   1      asynchronous, active-high reset
//   mode     in   2      direct op when idle: 00 hold, 01 right, 10 left, 11 load
//   sin_r    in   1      serial in for right shifts; enters Q[WIDTH-1]
//   sin_l    in   1      serial in for left shifts; enters Q[0]
//   d        in   WIDTH  parallel load data
//   start    in   1      burst request, sampled only when idle
//   dir      in   1      burst direction: 0 right, 1 left; latched on start
//   amt      in   CW     burst shift count; latched on start
//   Q        out  WIDTH  register contents
//   sout_r   out  1      = Q[0]; bit shifted out on a right shift
//   sout_l   out  1      = Q[WIDTH-1]; bit shifted out on a left shift
//   busy     out  1      high while a burst is in progress
//   done     out  1      one-cycle pulse when a burst completes
// BEHAVIOUR
//   Reset, asserted at any time including mid-burst:
//     Q=0, FSM=IDLE, busy=0, done=0, counter=0.
//     A burst in progress is aborted.
//   Right shift:   Q <= {fill, Q[WIDTH-1:1]}
//   Left shift:    Q <= {Q[WIDTH-2:0], fill}
//   FSM states: IDLE, SHIFT.
//   IDLE, start=0: mode is applied every edge.
//     Fill bit for direct shifts is sin_r or sin_l.
//   IDLE, start=1: start has priority over mode.
//     Q is held on that edge.
//     dir is latched; the count is min(amt, WIDTH).
//     count != 0: go to SHIFT, busy=1 from the next cycle.
//     count == 0: stay in IDLE, busy stays 0, done=1 on the next cycle.
//   SHIFT: one shift per edge in the latched dir; counter decrements.
//     mode, start, dir and amt are ignored.
//     The fill bit is taken from sin_r/sin_l as sampled on each edge.
//     On the edge that performs the last shift: go to IDLE, busy=0, done=1 for
//     exactly the following cycle.
//   Timing: start sampled at edge k, shifts occur at edges k+1 .. k+N.
//     Command-to-done latency is N+1 cycles.
//   done is registered and never stays high for 2 consecutive cycles from one burst.
//   A new start is accepted on the cycle done is high, since the FSM is IDLE then.
//   Outputs are registered except sout_r and sout_l, which are wired from Q.
// CONFIGURATION
//   ROTATE_SHIFT_EN defined: burst shifts rotate.
//     Fill bit is the bit shifted out: Q[0] going right, Q[WIDTH-1] going left.
//     sin_r and sin_l are ignored during SHIFT.
//   ROTATE_SHIFT_EN undefined: burst shifts use sin_r/sin_l as fill.
//   Direct mode (01/10) always uses sin_r/sin_l, whether or not the macro is defined.
// TESTING  (WIDTH=8)
//   reset=1 mid-burst, Q=8'h5A -> Q=8'h00, busy=0, done=0 immediately (async)
//   mode=11, d=8'hA5, then mode=01 with sin_r=1 -> Q=8'hA5, then Q=8'hD2
//   Q=8'h81, mode=10, sin_l=0, 2 cycles -> Q=8'h02, then Q=8'h04
//   Q=8'hF0, start, dir=0, amt=3, sin_r=0; macro off -> busy 3 cycles, Q=8'h1E, done 1 cycle
//   Same burst with ROTATE_SHIFT_EN defined, Q=8'hF1 -> Q=8'h3E, done 1 cycle
//   amt=0 -> busy=0, Q unchanged, done=1 next cycle
//   amt=12 -> clamped to 8 shifts (busy 8 cycles)
//   start and mode pulses while busy -> ignored, Q follows the burst only

Source files
------------

// File: rtl/univ_shift_register.sv
// Universal shift register with hold/right/left/load modes and an FSM-driven burst shifter.
// Define ROTATE_SHIFT_EN to make burst shifts rotate instead of using sin_r/sin_l as fill.
module univ_shift_register #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic [CW-1:0]    amt,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic [CW-1:0]    amt_clamped;
    logic             burst_fill;
    logic [WIDTH-1:0] burst_next;

    assign sout_r = Q[0];
    assign sout_l = Q[WIDTH-1];

    always_comb begin
        amt_clamped = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;
    end

    always_comb begin
`ifdef ROTATE_SHIFT_EN
        burst_fill = dir_q ? Q[WIDTH-1] : Q[0];
`else
        burst_fill = dir_q ? sin_l : sin_r;
`endif
        burst_next = dir_q ? {Q[WIDTH-2:0], burst_fill} : {burst_fill, Q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q     <= '0;
            state <= StIdle;
            cnt   <= '0;
            dir_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        // Q holds on the accepting edge; a zero-length burst completes at once
                        dir_q <= dir;
                        if (amt_clamped != '0) begin
                            cnt   <= amt_clamped;
                            state <= StShift;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end else begin
                        unique case (mode)
                            2'b00: Q <= Q;
                            2'b01: Q <= {sin_r, Q[WIDTH-1:1]};
                            2'b10: Q <= {Q[WIDTH-2:0], sin_l};
                            2'b11: Q <= d;
                        endcase
                    end
                end
                StShift: begin
                    Q   <= burst_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_register.sv
// Scoreboard bench for univ_shift_register: a driver pushes model predictions per cycle and a
// monitor compares them after each rising edge; directed cases add fixed-value checks.
module tb_univ_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic [W-1:0]  d = '0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [CW-1:0] amt = '0;
    logic [W-1:0]  Q;
    logic          sout_r, sout_l, busy, done;

    univ_shift_register #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d      (d),
        .start  (start),
        .dir    (dir),
        .amt    (amt),
        .Q      (Q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register value plus number of burst shifts still owed
    logic [W-1:0] m_q;
    int           m_left;
    logic         m_dir;
    logic         m_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q    = '0;
        m_left = 0;
        m_dir  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] md, input logic sr, input logic sl,
                              input logic [W-1:0] dd, input logic st, input logic dr,
                              input logic [CW-1:0] am);
        logic fill;
        int   n;
        m_done = 1'b0;
        if (m_left > 0) begin
`ifdef ROTATE_SHIFT_EN
            fill = m_dir ? m_q[W-1] : m_q[0];
`else
            fill = m_dir ? sl : sr;
`endif
            if (m_dir) m_q = (m_q << 1) | W'(fill);
            else       m_q = (m_q >> 1) | (W'(fill) << (W - 1));
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (st) begin
            n     = (int'(am) > W) ? W : int'(am);
            m_dir = dr;
            if (n == 0) m_done = 1'b1;
            else        m_left = n;
        end else begin
            case (md)
                2'b01:   m_q = (m_q >> 1) | (W'(sr) << (W - 1));
                2'b10:   m_q = (m_q << 1) | W'(sl);
                2'b11:   m_q = dd;
                default: m_q = m_q;
            endcase
        end
    endtask

    // One clock of stimulus: drive at the falling edge and queue the post-edge prediction
    task automatic drive(input logic [1:0] md, input logic sr, input logic sl,
                         input logic [W-1:0] dd, input logic st, input logic dr,
                         input logic [CW-1:0] am);
        exp_t e;
        @(negedge clk);
        mode = md; sin_r = sr; sin_l = sl; d = dd; start = st; dir = dr; amt = am;
        model_step(md, sr, sl, dd, st, dr, am);
        e.q    = m_q;
        e.busy = (m_left > 0);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_q", 32'(Q), 32'(e.q));
                chk("sb_busy", 32'(busy), 32'(e.busy));
                chk("sb_done", 32'(done), 32'(e.done));
                chk("sb_sout_r", 32'(sout_r), 32'(e.q[0]));
                chk("sb_sout_l", 32'(sout_l), 32'(e.q[W-1]));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int busy_cycles;
        logic [W-1:0] burst_exp;
        model_reset();
        reset = 1'b1;
        #12;
        chk("reset_q", 32'(Q), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Load then right shift with sin_r=1
        drive(2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, '0);
        after_edge(); chk("load_a5", 32'(Q), 32'hA5);
        drive(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0);
        after_edge(); chk("right_d2", 32'(Q), 32'hD2);

        // Left shifts dropping the top bit
        drive(2'b11, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, '0);
        drive(2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
        after_edge(); chk("left_02", 32'(Q), 32'h02);
        drive(2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
        after_edge(); chk("left_04", 32'(Q), 32'h04);

        // Burst right by 3 while start/mode pulses are ignored
`ifdef ROTATE_SHIFT_EN
        drive(2'b11, 1'b0, 1'b0, 8'hF1, 1'b0, 1'b0, '0);
        burst_exp = 8'h3E;
`else
        drive(2'b11, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, '0);
        burst_exp = 8'h1E;
`endif
        drive(2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, CW'(3));
        after_edge(); chk("burst_busy_start", 32'(busy), 32'h1);
        drive(2'b11, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, CW'(1));
        drive(2'b10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, CW'(5));
        drive(2'b11, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, '0);
        after_edge();
        chk("burst_q", 32'(Q), 32'(burst_exp));
        chk("burst_done", 32'(done), 32'h1);
        chk("burst_busy_end", 32'(busy), 32'h0);
        drive(2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
        after_edge(); chk("done_one_cycle", 32'(done), 32'h0);

        // Zero-length burst
        drive(2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, CW'(0));
        after_edge();
        chk("amt0_busy", 32'(busy), 32'h0);
        chk("amt0_q", 32'(Q), 32'(burst_exp));
        chk("amt0_done", 32'(done), 32'h1);

        // Oversized amount clamps to W shifts
        drive(2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, CW'(12));
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            drive(2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, '0);
            if (busy) busy_cycles++;
        end
        chk("amt12_busy_cycles", 32'(busy_cycles), 32'd8);

        // Asynchronous reset in the middle of a burst
        drive(2'b11, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, '0);
        drive(2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, CW'(6));
        drive(2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0);
        after_edge();
        chk("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_q", 32'(Q), 32'h00);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_done", 32'(done), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
        after_edge(); chk("post_reset_idle", 32'(busy), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom), CW'($urandom_range(0, 2**CW - 1)));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
